alloc_scheduler: RTL
====================

# alloc_scheduler

Shares the block-based dynamic memory allocator between several requesters. Each requester issues an allocate request carrying a 6-bit size. The scheduler arbitrates round-robin, maps the size to a power-of-two size class, and claims the lowest free slot of that class from an internal occupancy bitmap. It then returns a handle. A single free port releases handles back to the pool. The block sits between the client ports and the block memory, and owns all allocation state.

## Interface
Parameters:
- NUM_REQ, 4: number of allocate requesters (2..8).
- SIZE_W, 6: request size width; fixes NUM_CLASS = SIZE_W = 6.
- SLOTS, 4: slots per size class (power of two, ≥2); SLOT_W = clog2(SLOTS).

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: synchronous, active-high.
- req_valid, in, NUM_REQ: per-requester allocate request.
- req_size, in, NUM_REQ*SIZE_W: packed sizes; requester i at bits [i*SIZE_W +: SIZE_W].
- req_ready, out, NUM_REQ: one-hot accept pulse for the granted requester.
- resp_valid, out, 1: response available.
- resp_ready, in, 1: consumer takes the response.
- resp_id, out, clog2(NUM_REQ): requester the response belongs to.
- resp_ok, out, 1: 1 = slot granted; 0 = rejected (bad size or class full).
- resp_class, out, 3: size class index.
- resp_slot, out, SLOT_W: slot within the class.
- free_valid, in, 1: release request.
- free_class, in, 3: class of the handle being released.
- free_slot, in, SLOT_W: slot of the handle being released.
- free_ready, out, 1: release accepted this cycle.
- err_double_free, out, 1: one-cycle pulse when a free targets a slot that is not allocated, or a class ≥ NUM_CLASS.
- busy, out, 1: FSM not in IDLE.

## Operation
Size class rule: the class is the smallest k with 2^k ≥ size.
- Size 1 → class 0.
- Size 2 → class 1.
- Sizes 3–4 → class 2.
- Sizes 5–8 → class 3.
- Sizes 9–16 → class 4.
- Sizes 17–32 → class 5.
- Size 0 or sizes 33–63 → reject (resp_ok=0, resp_class=0, resp_slot=0).

Occupancy: NUM_CLASS×SLOTS bitmap, 1 = allocated. Allocation picks the lowest-index free slot in the class. If the class is full, the request is rejected and the bitmap is unchanged.

FSM states: IDLE, LOOKUP, RESP.
- IDLE, free_valid=1: free_ready=1 combinationally. The bitmap bit clears at the clock edge. If the bit was already 0, or the class is invalid, err_double_free pulses and nothing changes. State stays IDLE. Allocate requests wait that cycle, so free has priority.
- IDLE, no free and any req_valid:
  - Round-robin grant starting from rr_ptr.
  - req_ready[winner]=1 for that cycle.
  - Latch the winner id and size.
  - rr_ptr ← winner+1 (mod NUM_REQ).
  - Go to LOOKUP.
- LOOKUP: compute class and slot, set the bitmap bit on success, load the response registers, assert resp_valid. Go to RESP.
- RESP: hold all resp_* stable until resp_ready=1, then go to IDLE. free_ready=0 and req_ready=0 while in LOOKUP and RESP.

## Timing
- Request accepted in cycle T (req_ready high). resp_valid is high from T+2. The earliest next accept is the cycle after the response handshake.
- Free latency: 1 cycle. The bitmap update is visible to a LOOKUP in the next cycle.
- Reset values:
  - req_ready=0, resp_valid=0, resp_ok=0, resp_id=0, resp_class=0, resp_slot=0.
  - free_ready=0, err_double_free=0, busy=0.
  - rr_ptr=0, bitmap all free, state IDLE.
- Reset mid-operation: abandons any pending LOOKUP or RESP. No response is issued, and all slots return to free.
- Requester drops req_valid without req_ready: no effect.
- Requester holds req_valid after being served: it is rearbitrated fairly after its peers.
- Simultaneous free and request in IDLE: free is served first. The request is granted in the next IDLE cycle.

## Structure
- Shared package alloc_pkg:
  - NUM_CLASS.
  - The state enum {IDLE, LOOKUP, RESP}.
  - Function size_to_class returning {valid, class}.
  - Function lowest_free returning {found, slot}.
- One sub-module, alloc_rr_arbiter: NUM_REQ-wide round-robin arbiter. Inputs: request vector, pointer. Outputs: one-hot grant, encoded index, any.
- Everything else lives in alloc_scheduler.

## Test plan
- Reset, then requester 0 size 1 → req_ready=4'b0001 at T, resp_valid at T+2 with id 0, ok 1, class 0, slot 0. Second size-2 request → class 1 slot 0.
- All four requesters valid continuously with sizes 5/9/17/3 → grants in order 0,1,2,3,0…. Responses: classes 3/4/5/2 with slots 0, then slot 1 on the second round.
- Five size-8 requests → slots 0–3 ok, fifth resp_ok=0. Free class 3 slot 2, then a size-8 request → slot 2.
- Size 0 and size 40 → resp_ok=0, class 0, slot 0. Bitmap unchanged, checked by a subsequent size-1 request returning slot 0.
- Free class 1 slot 3 when it is not allocated → err_double_free one-cycle pulse, free_ready=1, later allocations unaffected. Free class 6 → err_double_free pulse.
- resp_ready held low 10 cycles → resp_* stable, req_ready stays 0. Assert reset during RESP → next cycle resp_valid=0, busy=0, size-1 request gets slot 0.

Source files
------------

// File: rtl/alloc_pkg.sv
// Shared types and helpers for the block allocator scheduler: state encoding,
// size-to-class mapping and lowest-free-slot search.
package alloc_pkg;

    localparam int unsigned NUM_CLASS  = 6;
    localparam int unsigned CLASS_W    = 3;
    localparam int unsigned MAX_SLOTS  = 32;
    localparam int unsigned MAX_SLOT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        RESP
    } state_e;

    typedef struct packed {
        logic               valid;
        logic [CLASS_W-1:0] cls;
    } class_res_t;

    typedef struct packed {
        logic                  found;
        logic [MAX_SLOT_W-1:0] slot;
    } slot_res_t;

    // Smallest k with 2^k >= size; size 0 or anything above 2^(NUM_CLASS-1) is invalid.
    function automatic class_res_t size_to_class(input logic [NUM_CLASS-1:0] size);
        class_res_t res;
        res = '0;
        if (size != '0) begin
            for (int k = int'(NUM_CLASS) - 1; k >= 0; k--) begin
                if (32'(size) <= (32'd1 << k)) begin
                    res.valid = 1'b1;
                    res.cls   = CLASS_W'(k);
                end
            end
        end
        return res;
    endfunction

    // Lowest index with a clear occupancy bit; unused upper bits must be passed as 1.
    function automatic slot_res_t lowest_free(input logic [MAX_SLOTS-1:0] occ);
        slot_res_t res;
        res = '0;
        for (int s = int'(MAX_SLOTS) - 1; s >= 0; s--) begin
            if (!occ[s]) begin
                res.found = 1'b1;
                res.slot  = MAX_SLOT_W'(s);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alloc_rr_arbiter.sv
// Round-robin arbiter: the first active request at or after ptr_i wins.
module alloc_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_c_o,
    output logic [IDX_W-1:0]   idx_c_o,
    output logic               any_c_o
);

    int unsigned cand;

    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        any_c_o = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = (32'(ptr_i) + i) % NUM_REQ;
            if (!any_c_o && req_i[IDX_W'(cand)]) begin
                any_c_o                = 1'b1;
                gnt_c_o[IDX_W'(cand)] = 1'b1;
                idx_c_o                = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alloc_scheduler.sv
// Arbitrates allocate requests round-robin, claims the lowest free slot of the
// request's power-of-two class and returns a handle; a free port releases handles.
module alloc_scheduler
    import alloc_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned SIZE_W  = 6,
    parameter int unsigned SLOTS   = 4,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ),
    localparam int unsigned SLOT_W = $clog2(SLOTS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*SIZE_W-1:0] req_size,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [IDX_W-1:0]          resp_id,
    output logic                      resp_ok,
    output logic [CLASS_W-1:0]        resp_class,
    output logic [SLOT_W-1:0]         resp_slot,
    input  logic                      free_valid,
    input  logic [CLASS_W-1:0]        free_class,
    input  logic [SLOT_W-1:0]         free_slot,
    output logic                      free_ready,
    output logic                      err_double_free,
    output logic                      busy
);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]               id_q, id_d;
    logic [SIZE_W-1:0]              size_q, size_d;
    logic [NUM_CLASS-1:0][SLOTS-1:0] bitmap_q, bitmap_d;
    logic                           resp_valid_q, resp_valid_d;
    logic                           resp_ok_q, resp_ok_d;
    logic [IDX_W-1:0]               resp_id_q, resp_id_d;
    logic [CLASS_W-1:0]             resp_class_q, resp_class_d;
    logic [SLOT_W-1:0]              resp_slot_q, resp_slot_d;

    logic [NUM_REQ-1:0]             arb_gnt;
    logic [IDX_W-1:0]               arb_idx;
    logic                           arb_any;
    class_res_t                     cls_res;
    slot_res_t                      slot_res;
    logic [MAX_SLOTS-1:0]           row_ext;

    alloc_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_c_o (arb_gnt),
        .idx_c_o (arb_idx),
        .any_c_o (arb_any)
    );

    assign cls_res = size_to_class(NUM_CLASS'(size_q));

    // Slots beyond SLOTS read as occupied so the search never returns them.
    always_comb begin
        row_ext            = '1;
        row_ext[SLOTS-1:0] = bitmap_q[cls_res.cls];
    end

    assign slot_res = lowest_free(row_ext);

    always_comb begin
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        id_d            = id_q;
        size_d          = size_q;
        bitmap_d        = bitmap_q;
        resp_valid_d    = resp_valid_q;
        resp_ok_d       = resp_ok_q;
        resp_id_d       = resp_id_q;
        resp_class_d    = resp_class_q;
        resp_slot_d     = resp_slot_q;
        req_ready       = '0;
        free_ready      = 1'b0;
        err_double_free = 1'b0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    // Frees take priority; allocate requests simply wait a cycle.
                    if (free_valid) begin
                        free_ready = 1'b1;
                        if ((free_class < CLASS_W'(NUM_CLASS)) && bitmap_q[free_class][free_slot]) begin
                            bitmap_d[free_class][free_slot] = 1'b0;
                        end else begin
                            err_double_free = 1'b1;
                        end
                    end else if (arb_any) begin
                        req_ready = arb_gnt;
                        id_d      = arb_idx;
                        size_d    = req_size[32'(arb_idx)*SIZE_W +: SIZE_W];
                        rr_ptr_d  = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
                        state_d   = LOOKUP;
                    end
                end
                LOOKUP: begin
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    if (cls_res.valid && slot_res.found) begin
                        resp_ok_d    = 1'b1;
                        resp_class_d = cls_res.cls;
                        resp_slot_d  = SLOT_W'(slot_res.slot);
                        bitmap_d[cls_res.cls][SLOT_W'(slot_res.slot)] = 1'b1;
                    end else begin
                        resp_ok_d    = 1'b0;
                        resp_class_d = '0;
                        resp_slot_d  = '0;
                    end
                    state_d = RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid_d = 1'b0;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            id_q         <= '0;
            size_q       <= '0;
            bitmap_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_ok_q    <= 1'b0;
            resp_id_q    <= '0;
            resp_class_q <= '0;
            resp_slot_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            id_q         <= id_d;
            size_q       <= size_d;
            bitmap_q     <= bitmap_d;
            resp_valid_q <= resp_valid_d;
            resp_ok_q    <= resp_ok_d;
            resp_id_q    <= resp_id_d;
            resp_class_q <= resp_class_d;
            resp_slot_q  <= resp_slot_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_ok    = resp_ok_q;
    assign resp_id    = resp_id_q;
    assign resp_class = resp_class_q;
    assign resp_slot  = resp_slot_q;
    assign busy       = (state_q != IDLE);

endmodule
